// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared CPU fetch definitions: data/address widths, PC increment
//            and the fetch entry record carried from memory to decode.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

  // One buffered fetch result: instruction word plus the PC it came from.
  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_if
// Purpose  : Bundles the instruction-memory address/data pair, the redirect
//            request and the decode-side valid/ready output of the fetch unit.
// Ports    : master - fetch unit side (drives imem_addr and out_*)
//            slave  - environment side (memory, branch unit, decoder)
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_data;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [INST_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  align_err;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output align_err
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  align_err
  );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry synchronous FIFO of fetch entries with push, pop and
//            a flush that empties it in one cycle.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            push, push_data     - write one entry (never while full)
//            pop                 - discard head (never while empty)
//            flush               - drop all entries, overrides push/pop
//            head                - entry at the read pointer
//            count               - number of valid entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire fetch_entry_t               push_data,
  input  wire logic                       pop,
  input  wire logic                       flush,
  output fetch_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t                 mem [DEPTH];
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [$clog2(DEPTH+1)-1:0]   cnt;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch unit. Holds the PC, issues one word address
//            per cycle to a one-cycle-latency instruction memory while buffer
//            space allows, and queues returned words for decode. A redirect
//            retargets the PC and discards in-flight and buffered words.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - inst_fetch_if.master (imem_addr/imem_data, redirect,
//                       redirect_pc, out_valid/out_ready/out_inst/out_pc,
//                       align_err)
// Config   : INST_FETCH_ALIGN_CHECK_EN - flag misaligned redirect targets on
//            align_err (sticky until reset) and force word alignment.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int                    DEPTH    = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  inst_fetch_if.master bus
);

  localparam int                 CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W+1:0]   DEPTH_L = (CNT_W+2)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [ADDR_WIDTH-1:0] pc_target;
  logic                  inflight;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CNT_W-1:0]      count;
  logic [CNT_W+1:0]      occupancy;
  fetch_entry_t          head;
  fetch_entry_t          push_entry;

  assign pop = bus.out_valid && bus.out_ready;

  // Slots that will be committed after this cycle if nothing new is issued.
  // pop implies count >= 1, so this never underflows.
  assign occupancy = {2'b00, count}
                   + {{(CNT_W+1){1'b0}}, inflight}
                   - {{(CNT_W+1){1'b0}}, pop};

  // Issuing only while a slot is reserved guarantees every response fits.
  assign issue = !bus.redirect && (occupancy < DEPTH_L);

  // A response landing in a redirect cycle belongs to the old path.
  assign push = inflight && !bus.redirect;

  assign push_entry.inst = bus.imem_data;
  assign push_entry.pc   = inflight_pc;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic align_err_q;

  assign pc_target = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      align_err_q <= 1'b0;
    end else if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
      align_err_q <= 1'b1;
    end
  end

  assign bus.align_err = align_err_q;
`else
  assign pc_target     = bus.redirect_pc;
  assign bus.align_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (bus.redirect) begin
      pc       <= pc_target;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + PC_STEP;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != '0);
  // Gate the head so stale storage never shows when the buffer is empty.
  assign bus.out_inst  = bus.out_valid ? head.inst : '0;
  assign bus.out_pc    = bus.out_valid ? head.pc   : '0;

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit that drives the address side of the synchronous instruction memory and delivers fetched instructions to decode. It holds the PC, issues one word address per cycle while buffer space allows, and captures the one-cycle-latency read data into a 2-entry FIFO. A redirect input (branch/jump) retargets the PC and discards in-flight and buffered words. Sits between `InstMemory` and the decode stage of the CPU.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `DEPTH`, 2, output FIFO entries (power of two, ≥2)
- `clk` input 1 system clock, all state on rising edge
- `rst` input 1 reset, synchronous, active-high
- `imem_addr` output 32 byte address presented to `InstMemory`
- `imem_data` input 32 read data; valid the cycle after the address was sampled
- `redirect` input 1 load new PC this cycle
- `redirect_pc` input 32 new PC target
- `out_valid` output 1 FIFO head valid
- `out_ready` input 1 decode accepts head
- `out_inst` output 32 instruction word at head
- `out_pc` output 32 PC of `out_inst`
- `align_err` output 1 misaligned redirect target (only with `INST_FETCH_ALIGN_CHECK_EN`; otherwise tied 0)

## Operation
- State: `pc`, `inflight` (1 bit), `inflight_pc`, FIFO `count` (0..DEPTH), read/write pointers.
- Issue condition: `issue = !redirect && (count + inflight - pop < DEPTH)`, where `pop = out_valid && out_ready`.
- `imem_addr = pc` combinationally at all times; on `issue`, `pc <= pc + 4`, `inflight <= 1`, `inflight_pc <= pc`; else `inflight <= 0`.
- Cycle after issue: if `inflight`, push `{imem_data, inflight_pc}` into FIFO.
- Pop on `out_valid && out_ready`; push and pop in the same cycle allowed, `count` unchanged.
- Redirect: `pc <= redirect_pc`, `inflight <= 0`, FIFO flushed (`count <= 0`). Response returning that cycle is dropped. No issue in the redirect cycle; fetch from `redirect_pc` starts next cycle.
- Redirect and pop same cycle: pop counts as accepted (decoder owns it); flush still applies to everything else.
- `pc` wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- Never pushes when full: issue condition guarantees a slot for every in-flight response.

## Timing
- Reset values: `pc=RESET_PC`, `imem_addr=RESET_PC`, `inflight=0`, `count=0`, `out_valid=0`, `out_inst=0`, `out_pc=0`, `align_err=0`.
- Reset mid-operation: all of the above in the next cycle; in-flight response discarded.
- Latency: address issued in cycle N → `out_valid` with that word in cycle N+2 (memory reads at N, FIFO written at end of N+1).
- Steady state with `out_ready=1`: one instruction per cycle after a 2-cycle fill.
- Redirect in cycle R → `imem_addr=redirect_pc` in R+1 → target word on `out_*` in R+3.
- `out_valid` held and `out_inst`/`out_pc` stable while `out_ready=0`.

## Configuration
- `INST_FETCH_ALIGN_CHECK_EN` defined: on redirect with `redirect_pc[1:0] != 0`, `align_err` registers 1 and stays set until reset; PC loaded with `{redirect_pc[31:2],2'b00}`.
- Not defined: no check, `align_err` constant 0, `redirect_pc` loaded unmodified.

## Structure
- Shared CPU package: `INST_WIDTH=32`, `ADDR_WIDTH=32`, `PC_STEP=4`, fetch entry struct `{inst, pc}`.
- One sub-module: `fetch_fifo` (DEPTH-entry synchronous FIFO with push/pop/flush, count output).

## Test plan
- Reset with `RESET_PC=0x100`, `out_ready=1` → `imem_addr` 0x100, 0x104, 0x108…; `out_valid` first high 2 cycles after reset release with `out_pc=0x100`, then one per cycle.
- Hold `out_ready=0` for 5 cycles → FIFO fills to 2, `imem_addr` freezes, no word lost or duplicated; release → `out_pc` continues contiguously.
- Redirect to 0x400 while FIFO full and one in flight → next cycle `imem_addr=0x400`, `out_valid=0`; first output `out_pc=0x400` at R+3.
- Redirect coincident with pop of `out_pc=0x10` → 0x10 accepted once, next output is redirect target.
- `pc` at 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With macro: redirect to 0x202 → `align_err=1`, fetch resumes at 0x200; without macro `align_err` stays 0 and fetch uses 0x202.
